// File: rtl/delay_stats.sv
// Windowed min/max/floor-average over 2^LOG2_N accepted timer samples, with a
// held result presented through a valid/ack handshake while the next window fills.
module delay_stats #(
    parameter int unsigned LOG2_N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    input  logic        clear,
    input  logic        result_ack,
    output logic [15:0] out_min,
    output logic [15:0] out_max,
    output logic [15:0] out_avg,
    output logic        result_valid,
    output logic        overrun,
    output logic [7:0]  rejected
);

    localparam int unsigned N  = 1 << LOG2_N;
    localparam int unsigned SW = 16 + LOG2_N;

    logic [15:0]     run_min;
    logic [15:0]     run_max;
    logic [SW-1:0]   run_sum;
    logic [LOG2_N:0] cnt;

    logic            accept;
    logic            reject;
    logic            complete;
    logic [15:0]     nxt_min;
    logic [15:0]     nxt_max;
    logic [SW-1:0]   nxt_sum;

    // Values at or above 0x8000 are timer glitches and never enter a window.
    always_comb begin
        accept   = sample_valid && !sample[15] && !clear;
        reject   = sample_valid &&  sample[15] && !clear;
        nxt_min  = (sample < run_min) ? sample : run_min;
        nxt_max  = (sample > run_max) ? sample : run_max;
        nxt_sum  = run_sum + SW'(sample);
        complete = accept && (cnt == (LOG2_N + 1)'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_min      <= 16'hFFFF;
            run_max      <= 16'h0000;
            run_sum      <= '0;
            cnt          <= '0;
            out_min      <= 16'hFFFF;
            out_max      <= 16'h0000;
            out_avg      <= 16'h0000;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            rejected     <= 8'd0;
        end else begin
            // A completing window below overrides this drop in the same cycle.
            if (result_ack) begin
                result_valid <= 1'b0;
            end
            if (clear) begin
                run_min  <= 16'hFFFF;
                run_max  <= 16'h0000;
                run_sum  <= '0;
                cnt      <= '0;
                overrun  <= 1'b0;
                rejected <= 8'd0;
            end else begin
                if (reject && rejected != 8'hFF) begin
                    rejected <= rejected + 8'd1;
                end
                if (accept) begin
                    if (complete) begin
                        run_min <= 16'hFFFF;
                        run_max <= 16'h0000;
                        run_sum <= '0;
                        cnt     <= '0;
                        if (!result_valid || result_ack) begin
                            out_min      <= nxt_min;
                            out_max      <= nxt_max;
                            out_avg      <= nxt_sum[LOG2_N +: 16];
                            result_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        run_min <= nxt_min;
                        run_max <= nxt_max;
                        run_sum <= nxt_sum;
                        cnt     <= cnt + (LOG2_N + 1)'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_delay_stats.sv
// Bench for delay_stats: a queue-based window model checked every cycle, plus
// hand-computed literal expectations at the key points of each scenario.
module tb_delay_stats;

    localparam int unsigned LOG2_N = 4;
    localparam int unsigned N      = 1 << LOG2_N;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sample = 16'h0;
    logic        sample_valid = 1'b0;
    logic        clear = 1'b0;
    logic        result_ack = 1'b0;
    logic [15:0] out_min;
    logic [15:0] out_max;
    logic [15:0] out_avg;
    logic        result_valid;
    logic        overrun;
    logic [7:0]  rejected;

    delay_stats #(.LOG2_N(LOG2_N)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .clear        (clear),
        .result_ack   (result_ack),
        .out_min      (out_min),
        .out_max      (out_max),
        .out_avg      (out_avg),
        .result_valid (result_valid),
        .overrun      (overrun),
        .rejected     (rejected)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Model state: what the outputs must show after the next rising edge.
    int unsigned win[$];
    int unsigned m_min = 16'hFFFF;
    int unsigned m_max = 0;
    int unsigned m_avg = 0;
    bit          m_valid = 1'b0;
    bit          m_ovr = 1'b0;
    int unsigned m_rej = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_step(input bit r, input bit sv, input logic [15:0] s,
                              input bit clr, input bit ack);
        bit          held;
        int unsigned mn, mx, sm;
        if (r) begin
            win.delete();
            m_min = 16'hFFFF; m_max = 0; m_avg = 0;
            m_valid = 1'b0; m_ovr = 1'b0; m_rej = 0;
            return;
        end
        held = m_valid;
        if (ack) m_valid = 1'b0;
        if (clr) begin
            win.delete();
            m_ovr = 1'b0;
            m_rej = 0;
        end else if (sv && s[15]) begin
            if (m_rej < 255) m_rej++;
        end else if (sv) begin
            win.push_back(int'(s));
            if (win.size() == N) begin
                mn = 32'hFFFF; mx = 0; sm = 0;
                foreach (win[i]) begin
                    if (win[i] < mn) mn = win[i];
                    if (win[i] > mx) mx = win[i];
                    sm += win[i];
                end
                if (!held || ack) begin
                    m_min = mn; m_max = mx; m_avg = sm / N;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
                win.delete();
            end
        end
    endtask

    task automatic drive(input bit r, input bit sv, input logic [15:0] s,
                         input bit clr, input bit ack);
        @(negedge clk);
        #1;
        rst = r; sample_valid = sv; sample = s; clear = clr; result_ack = ack;
        model_step(r, sv, s, clr, ack);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic feed(input logic [15:0] s);
        drive(1'b0, 1'b1, s, 1'b0, 1'b0);
    endtask

    task automatic lit(input string tag, input logic [15:0] mn, input logic [15:0] mx,
                       input logic [15:0] av, input bit v, input bit ov);
        check({tag, ".min"}, 32'(out_min), 32'(mn));
        check({tag, ".max"}, 32'(out_max), 32'(mx));
        check({tag, ".avg"}, 32'(out_avg), 32'(av));
        check({tag, ".valid"}, 32'(result_valid), 32'(v));
        check({tag, ".overrun"}, 32'(overrun), 32'(ov));
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc.min", 32'(out_min), m_min);
            check("cyc.max", 32'(out_max), m_max);
            check("cyc.avg", 32'(out_avg), m_avg);
            check("cyc.valid", 32'(result_valid), 32'(m_valid));
            check("cyc.overrun", 32'(overrun), 32'(m_ovr));
            check("cyc.rejected", 32'(rejected), m_rej);
        end
    end

    initial begin
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        chk_en = 1'b1;
        idle();
        lit("reset", 16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0);
        check("reset.rejected", 32'(rejected), 32'd0);

        // Samples 1..16 -> 1/16/8.
        for (int i = 1; i <= 16; i++) begin
            feed(16'(i));
            if (i == 15) check("w1.not_yet", 32'(result_valid), 32'd0);
        end
        idle();
        lit("w1", 16'd1, 16'd16, 16'd8, 1'b1, 1'b0);

        // Dropped window of 100s while held.
        for (int i = 0; i < 16; i++) feed(16'd100);
        idle();
        lit("drop", 16'd1, 16'd16, 16'd8, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        idle();
        check("ack.valid", 32'(result_valid), 32'd0);

        // Clear overrun; window of 10s, then 0x7FFF window with ack on its last edge.
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) feed(16'd10);
        idle();
        lit("w10", 16'd10, 16'd10, 16'd10, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) feed(16'h7FFF);
        drive(1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        idle();
        lit("w7fff", 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Rejects interleaved among 16 fives.
        for (int i = 0; i < 16; i++) begin
            feed(16'd5);
            if (i == 3) feed(16'h8000);
            if (i == 9) feed(16'hDEAD);
            if (i == 14) begin
                idle();
                check("rej.not_yet", 32'(result_valid), 32'd0);
            end
        end
        idle();
        lit("rej", 16'd5, 16'd5, 16'd5, 1'b1, 1'b0);
        check("rej.count", 32'(rejected), 32'd2);

        // 8 partial samples, clear (with an ignored glitch sample), then 16 threes.
        for (int i = 0; i < 8; i++) feed(16'd1000);
        drive(1'b0, 1'b1, 16'h8000, 1'b1, 1'b0);
        idle();
        lit("clr", 16'd5, 16'd5, 16'd5, 1'b1, 1'b0);
        check("clr.rejected", 32'(rejected), 32'd0);
        drive(1'b0, 1'b1, 16'd3, 1'b0, 1'b1);
        for (int i = 1; i < 16; i++) feed(16'd3);
        idle();
        lit("w3", 16'd3, 16'd3, 16'd3, 1'b1, 1'b0);

        // Reject counter saturation.
        for (int i = 0; i < 260; i++) feed(16'hFFFF);
        idle();
        check("rej.sat", 32'(rejected), 32'd255);

        // Reset mid-window while a result is held, then a fresh window of 2,4..32.
        for (int i = 0; i < 5; i++) feed(16'd7);
        drive(1'b1, 1'b1, 16'd7, 1'b0, 1'b0);
        idle();
        lit("rst", 16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0);
        check("rst.rejected", 32'(rejected), 32'd0);
        for (int i = 1; i <= 16; i++) feed(16'(2 * i));
        idle();
        lit("post", 16'd2, 16'd32, 16'd17, 1'b1, 1'b0);

        idle();
        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/delay_stats.md
# delay_stats

Windowed statistics stage downstream of the delay-measurement timer. It consumes the timer's 16-bit elapsed-cycle value and its one-cycle ready strobe. Over each window of 2^LOG2_N accepted samples it computes minimum, maximum and floor-average, and presents them to the readout/UART formatter through a valid/ack handshake. The next window accumulates while a result is being held.

## Interface
- LOG2_N, default 4: window size is N = 2^LOG2_N samples; legal range 1..8.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- sample  input  16  elapsed-cycle count from the timer; sampled only when sample_valid=1.
- sample_valid  input  1  one-cycle strobe from the timer (its ready output).
- clear  input  1  synchronous soft clear of the partial window and sticky flags.
- result_ack  input  1  consumer has taken the held result.
- out_min  output  16  minimum accepted sample of the last completed window.
- out_max  output  16  maximum accepted sample of the last completed window.
- out_avg  output  16  floor(sum/N) of the last completed window.
- result_valid  output  1  a result is held and unacknowledged.
- overrun  output  1  sticky; a completed window was dropped.
- rejected  output  8  saturating count of rejected samples.

## Operation
- Accept: sample_valid=1 and sample[15]=0 and clear=0.
- Reject: sample_valid=1 and sample[15]=1. The sample is discarded and rejected increments, saturating at 255. The timer never legitimately produces values at or above 0x8000.
- Accumulators:
  - run_min, init 16'hFFFF; run_max, init 0.
  - run_sum, width 16+LOG2_N; cannot overflow, since the max is 0x7FFF·N.
  - cnt, width LOG2_N+1.
- Each accepted sample updates run_min and run_max, adds to run_sum, and increments cnt.
- Window completion: the accepted sample makes cnt reach N. Min, max and sum include that sample. Then:
  - If result_valid=0, or result_ack=1 in the same cycle: latch out_min, out_max and out_avg = (sum incl. sample) >> LOG2_N, and set result_valid=1.
  - Otherwise: keep the held result unchanged, drop the new window, and set overrun=1.
  - In both cases, reinitialise the accumulators and set cnt=0.
- Handshake: result_valid stays 1 until a cycle with result_ack=1. It clears on the next edge unless a new window completes in that same cycle, in which case it stays 1 with the new values.
- result_ack while result_valid=0 is ignored.
- Outputs are stable while result_valid=1.
- clear: reinitialise the accumulators, cnt=0, overrun=0, rejected=0. Held outputs and result_valid are untouched. A sample_valid in the same cycle is ignored and not counted as rejected.
- rst: every register returns to its reset value, including mid-window and while a result is held.

## Timing
- Reset values: out_min=16'hFFFF, out_max=0, out_avg=0, result_valid=0, overrun=0, rejected=0, cnt=0, run_min=16'hFFFF, run_max=0, run_sum=0.
- All outputs are registered; no combinational input-to-output paths.
- Latency: on the edge that accepts the Nth sample, the outputs update. result_valid is high from the cycle after that edge.
- Back-to-back sample_valid on consecutive cycles is supported: one sample per cycle, no stall, no backpressure to the timer.
- Ack-to-drop: result_valid falls on the edge where result_ack=1 is sampled.
- Priority per cycle: rst > clear > sample accept/reject > ack.

## Test plan
- Reset, then samples 1..16 (LOG2_N=4), one per cycle -> one cycle after the 16th: result_valid=1, out_min=1, out_max=16, out_avg=8 (136>>4); overrun=0.
- Hold result without ack, then feed 16 more samples of 100 -> outputs still 1/16/8, overrun=1; ack -> result_valid=0 next cycle.
- Ack asserted on the same edge as the 16th sample of a second window of 0x7FFF -> result_valid stays 1, outputs 0x7FFF/0x7FFF/0x7FFF, overrun=0.
- Samples 0x8000 and 0xDEAD interleaved among 16 valid samples of 5 -> rejected=2, window completes with 5/5/5, only after the 16th valid sample.
- 8 samples, clear, then 16 samples of 3 -> first result 3/3/3; held outputs and result_valid from before the clear are unchanged by it.
- rst asserted mid-window and while result_valid=1 -> all outputs at reset values next cycle; a following full window produces a correct result.
